// File: rtl/tx_pkg.sv
// Shared constants for the PRBS9 QPSK transmitter: LFSR geometry, feedback taps,
// phase counter width and the default S(8,7) symbol levels.
package tx_pkg;

   localparam int unsigned LFSR_WIDTH = 9;
   localparam int unsigned TAP_HI     = 8;
   localparam int unsigned TAP_LO     = 4;

   localparam int unsigned OS_MIN     = 1;
   localparam int unsigned OS_MAX     = 16;
   localparam int unsigned PHASE_W    = 4;

   localparam logic signed [7:0] SYM_POS = 8'sh40;
   localparam logic signed [7:0] SYM_NEG = 8'shC0;

endpackage

// File: rtl/prbs9_lfsr.sv
// PRBS9 generator, polynomial x^9 + x^5 + 1. The emitted bit is the current MSB;
// one shift per asserted shift_en, so bit_c is the bit of the symbol being issued.
module prbs9_lfsr
   import tx_pkg::*;
#(
   parameter logic [LFSR_WIDTH-1:0] SEED = 9'h1AA
)(
   input  logic clock,
   input  logic reset,
   input  logic shift_en,
   output logic bit_c
);

   logic [LFSR_WIDTH-1:0] lfsr;

   // Shift register: reload seed on reset, advance one step per symbol.
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr <= SEED;
      end else if (shift_en) begin
         lfsr <= {lfsr[LFSR_WIDTH-2:0], lfsr[TAP_HI] ^ lfsr[TAP_LO]};
      end
   end

   assign bit_c = lfsr[TAP_HI];

endmodule

// File: rtl/prbs_qpsk_tx.sv
// PRBS9 QPSK symbol source with OS_FACTOR oversampling. Off-symbol samples repeat
// the symbol value by default; define TX_ZERO_STUFF_EN to emit zeros instead.
module prbs_qpsk_tx
   import tx_pkg::*;
#(
   parameter int unsigned           NB_OUTPUT  = 8,
   parameter int unsigned           NBF_OUTPUT = 7,
   parameter int unsigned           OS_FACTOR  = 4,
   parameter logic [LFSR_WIDTH-1:0] SEED_I     = 9'h1AA,
   parameter logic [LFSR_WIDTH-1:0] SEED_Q     = 9'h1FE
)(
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_enable,
   output logic                        o_valid,
   output logic                        o_strobe,
   output logic signed [NB_OUTPUT-1:0] o_symb_I,
   output logic signed [NB_OUTPUT-1:0] o_symb_Q,
   output logic                        o_bit_I,
   output logic                        o_bit_Q
);

   // Parameter legality checks, resolved at elaboration.
   if (SEED_I == '0) begin : g_err_seed_i
      $error("prbs_qpsk_tx: SEED_I must be nonzero");
   end
   if (SEED_Q == '0) begin : g_err_seed_q
      $error("prbs_qpsk_tx: SEED_Q must be nonzero");
   end
   if ((OS_FACTOR < OS_MIN) || (OS_FACTOR > OS_MAX)) begin : g_err_os
      $error("prbs_qpsk_tx: OS_FACTOR must be within 1..16");
   end
   if ((NBF_OUTPUT < 1) || (NBF_OUTPUT >= NB_OUTPUT)) begin : g_err_fmt
      $error("prbs_qpsk_tx: NBF_OUTPUT must be within 1..NB_OUTPUT-1");
   end

   localparam logic signed [NB_OUTPUT-1:0] MAG_GEN = NB_OUTPUT'(1) << (NBF_OUTPUT - 1);
   localparam bit DEFAULT_FMT = (NB_OUTPUT == 8) && (NBF_OUTPUT == 7);
   localparam logic signed [NB_OUTPUT-1:0] LVL_POS =
      DEFAULT_FMT ? NB_OUTPUT'(SYM_POS) : MAG_GEN;
   localparam logic signed [NB_OUTPUT-1:0] LVL_NEG =
      DEFAULT_FMT ? NB_OUTPUT'(SYM_NEG) : -MAG_GEN;
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OS_FACTOR - 1);

   logic [PHASE_W-1:0] phase;
   logic               sym_cycle_c;
   logic               bit_i_c;
   logic               bit_q_c;

   assign sym_cycle_c = i_enable && (phase == '0);

   // One generator per rail, stepped only on symbol cycles.
   prbs9_lfsr #(.SEED(SEED_I)) u_lfsr_i (
      .clock    (i_clock),
      .reset    (i_reset),
      .shift_en (sym_cycle_c),
      .bit_c    (bit_i_c)
   );

   prbs9_lfsr #(.SEED(SEED_Q)) u_lfsr_q (
      .clock    (i_clock),
      .reset    (i_reset),
      .shift_en (sym_cycle_c),
      .bit_c    (bit_q_c)
   );

   // Sample-phase counter: wraps at OS_FACTOR, frozen while disabled.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         phase <= '0;
      end else if (i_enable) begin
         phase <= (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
      end
   end

   // Output register: valid/strobe follow enable, data holds while disabled.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_valid  <= 1'b0;
         o_strobe <= 1'b0;
         o_bit_I  <= 1'b0;
         o_bit_Q  <= 1'b0;
         o_symb_I <= '0;
         o_symb_Q <= '0;
      end else begin
         o_valid  <= i_enable;
         o_strobe <= sym_cycle_c;
         if (sym_cycle_c) begin
            o_bit_I  <= bit_i_c;
            o_bit_Q  <= bit_q_c;
            o_symb_I <= bit_i_c ? LVL_NEG : LVL_POS;
            o_symb_Q <= bit_q_c ? LVL_NEG : LVL_POS;
         end else if (i_enable) begin
`ifdef TX_ZERO_STUFF_EN
            o_symb_I <= '0;
            o_symb_Q <= '0;
`else
            o_symb_I <= o_symb_I;
            o_symb_Q <= o_symb_Q;
`endif
         end
      end
   end

endmodule

// File: tb/tb_prbs_qpsk_tx.sv
// Bench for prbs_qpsk_tx: OS_FACTOR=4 and OS_FACTOR=1 instances share stimulus and
// are checked against a sequence-level reference (PRBS recurrence s[n+9]=s[n]^s[n+4]).
module tb_prbs_qpsk_tx;

   localparam bit ZS =
`ifdef TX_ZERO_STUFF_EN
      1'b1;
`else
      1'b0;
`endif
   localparam logic [8:0] SI = 9'h1AA;
   localparam logic [8:0] SQ = 9'h1FE;
   localparam int NSEQ = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   logic v4, s4, bi4, bq4, v1, s1, bi1, bq1;
   logic signed [7:0] si4, sq4, si1, sq1;

   int total = 0;
   int bad   = 0;

   logic pi [NSEQ];
   logic pq [NSEQ];

   // expected output vector {valid, strobe, bit_I, bit_Q, symb_I, symb_Q}
   logic [19:0] e4, e1;
   int cnt4, cnt1;

   always #5 clk = ~clk;

   prbs_qpsk_tx #(.OS_FACTOR(4)) dut4 (
      .i_clock(clk), .i_reset(rst), .i_enable(en),
      .o_valid(v4), .o_strobe(s4), .o_symb_I(si4), .o_symb_Q(sq4),
      .o_bit_I(bi4), .o_bit_Q(bq4)
   );

   prbs_qpsk_tx #(.OS_FACTOR(1)) dut1 (
      .i_clock(clk), .i_reset(rst), .i_enable(en),
      .o_valid(v1), .o_strobe(s1), .o_symb_I(si1), .o_symb_Q(sq1),
      .o_bit_I(bi1), .o_bit_Q(bq1)
   );

   function automatic logic [7:0] mapb(input logic b);
      return b ? 8'hC0 : 8'h40;
   endfunction

   task automatic build_seq();
      for (int k = 0; k < 9; k++) begin
         pi[k] = SI[8-k];
         pq[k] = SQ[8-k];
      end
      for (int n = 0; n + 9 < NSEQ; n++) begin
         pi[n+9] = pi[n] ^ pi[n+4];
         pq[n+9] = pq[n] ^ pq[n+4];
      end
   endtask

   task automatic upd(inout logic [19:0] e, inout int cnt, input int os);
      int ph, idx;
      if (rst) begin
         e = '0;
         cnt = 0;
      end else if (!en) begin
         e[19] = 1'b0;
         e[18] = 1'b0;
      end else begin
         ph  = cnt % os;
         idx = (cnt / os) % NSEQ;
         e[19] = 1'b1;
         e[18] = (ph == 0);
         e[17] = pi[idx];
         e[16] = pq[idx];
         e[15:8] = (ph == 0 || !ZS) ? mapb(pi[idx]) : 8'h00;
         e[7:0]  = (ph == 0 || !ZS) ? mapb(pq[idx]) : 8'h00;
         cnt++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      upd(e4, cnt4, 4);
      upd(e1, cnt1, 1);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         en = 1'($urandom_range(0, 1));
         if (c == 2) en = 1'b1;
         tick();
         total++;
         if ({v4, s4, bi4, bq4, si4, sq4} !== 20'h0) begin
            bad++;
            $display("FAIL reset4 cyc=%0d got=%h want=%h", c, {v4, s4, bi4, bq4, si4, sq4}, 20'h0);
         end
         total++;
         if ({v1, s1, bi1, bq1, si1, sq1} !== 20'h0) begin
            bad++;
            $display("FAIL reset1 cyc=%0d got=%h want=%h", c, {v1, s1, bi1, bq1, si1, sq1}, 20'h0);
         end
      end
   endtask

   task automatic test_first_symbols();
      logic [7:0] want [3];
      want[0] = 8'hC0; want[1] = 8'hC0; want[2] = 8'h40;
      rst = 1'b1; en = 1'b0; tick();
      rst = 1'b0; en = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         total++;
         if ({v4, s4, bi4, bq4, si4, sq4} !== e4) begin
            bad++;
            $display("FAIL first_vec cyc=%0d got=%h want=%h", c, {v4, s4, bi4, bq4, si4, sq4}, e4);
         end
         total++;
         if (s4 !== ((c % 4) == 0)) begin
            bad++;
            $display("FAIL strobe_every4 cyc=%0d got=%b want=%b", c, s4, (c % 4) == 0);
         end
         if ((c % 4) == 0) begin
            total++;
            if (si4 !== want[c/4]) begin
               bad++;
               $display("FAIL first_symb_I sym=%0d got=%h want=%h", c / 4, si4, want[c/4]);
            end
         end
      end
   endtask

   task automatic test_zero_stuff();
      logic [7:0] off;
      rst = 1'b1; en = 1'b0; tick();
      rst = 1'b0; en = 1'b1;
      off = ZS ? 8'h00 : 8'hC0;
      tick();
      total++;
      if (si4 !== 8'hC0 || sq4 !== 8'hC0) begin
         bad++;
         $display("FAIL stuff_ph0 got=%h/%h want=c0/c0", si4, sq4);
      end
      for (int p = 1; p < 4; p++) begin
         tick();
         total++;
         if (si4 !== off || sq4 !== off || bi4 !== 1'b1 || bq4 !== 1'b1) begin
            bad++;
            $display("FAIL stuff_ph%0d got=%h/%h bits=%b%b want=%h/%h bits=11",
                     p, si4, sq4, bi4, bq4, off, off);
         end
      end
   endtask

   task automatic test_enable_gaps();
      logic pat [6];
      logic prev_en;
      pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 0; pat[4] = 1; pat[5] = 1;
      rst = 1'b1; en = 1'b0; tick();
      rst = 1'b0;
      for (int c = 0; c < 6 + 300; c++) begin
         prev_en = en;
         if (c < 6) begin
            en = pat[c];
         end else begin
            en  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 24) == 0);
         end
         tick();
         total++;
         if ({v4, s4, bi4, bq4, si4, sq4} !== e4) begin
            bad++;
            $display("FAIL gaps4 cyc=%0d got=%h want=%h", c, {v4, s4, bi4, bq4, si4, sq4}, e4);
         end
         total++;
         if ({v1, s1, bi1, bq1, si1, sq1} !== e1) begin
            bad++;
            $display("FAIL gaps1 cyc=%0d got=%h want=%h", c, {v1, s1, bi1, bq1, si1, sq1}, e1);
         end
         if (c >= 1 && c < 6) begin
            total++;
            if (v4 !== en) begin
               bad++;
               $display("FAIL valid_delay cyc=%0d got=%b want=%b", c, v4, en);
            end
         end
         if (c == 4) begin
            total++;
            if (s4 !== 1'b0 || prev_en !== 1'b0) begin
               bad++;
               $display("FAIL resume_phase2 strobe got=%b want=0", s4);
            end
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; en = 1'b0; tick();
      rst = 1'b0; en = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1; en = 1'b1; tick();
      total++;
      if ({v4, s4, si4} !== 10'h0) begin
         bad++;
         $display("FAIL reset_mid_hold got=%h want=000", {v4, s4, si4});
      end
      rst = 1'b0; en = 1'b1; tick();
      total++;
      if (s4 !== 1'b1 || si4 !== 8'hC0 || v4 !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_restart got v=%b s=%b I=%h want v=1 s=1 I=c0", v4, s4, si4);
      end
      total++;
      if ({v4, s4, bi4, bq4, si4, sq4} !== e4) begin
         bad++;
         $display("FAIL reset_mid_vec got=%h want=%h", {v4, s4, bi4, bq4, si4, sq4}, e4);
      end
   endtask

   task automatic test_wrap();
      logic head [3];
      head[0] = 1'b1; head[1] = 1'b1; head[2] = 1'b0;
      rst = 1'b1; en = 1'b0; tick();
      rst = 1'b0; en = 1'b1;
      for (int c = 0; c < 514 * 4; c++) begin
         tick();
         total++;
         if (bi4 !== e4[17] || bq4 !== e4[16] || s4 !== e4[18]) begin
            bad++;
            $display("FAIL wrap_bits cyc=%0d got=%b%b%b want=%b%b%b",
                     c, s4, bi4, bq4, e4[18], e4[17], e4[16]);
         end
         if (c >= 511 * 4 && (c % 4) == 0) begin
            total++;
            if (bi4 !== head[c/4 - 511] || s4 !== 1'b1) begin
               bad++;
               $display("FAIL wrap_repeat sym=%0d got bit=%b s=%b want bit=%b s=1",
                        c / 4, bi4, s4, head[c/4 - 511]);
            end
         end
      end
   endtask

   task automatic test_os1();
      logic [7:0] want [3];
      want[0] = 8'hC0; want[1] = 8'hC0; want[2] = 8'h40;
      rst = 1'b1; en = 1'b0; tick();
      rst = 1'b0; en = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (si1 !== want[c] || s1 !== 1'b1) begin
            bad++;
            $display("FAIL os1_first sym=%0d got I=%h s=%b want I=%h s=1", c, si1, s1, want[c]);
         end
      end
      for (int c = 0; c < 100; c++) begin
         en = 1'($urandom_range(0, 1));
         tick();
         total++;
         if (s1 !== v1 || {v1, s1, bi1, bq1, si1, sq1} !== e1) begin
            bad++;
            $display("FAIL os1_rand cyc=%0d got=%h want=%h", c, {v1, s1, bi1, bq1, si1, sq1}, e1);
         end
      end
   endtask

   initial begin
      build_seq();
      e4 = '0; e1 = '0; cnt4 = 0; cnt1 = 0;
      test_reset();
      test_first_symbols();
      test_zero_stuff();
      test_enable_gaps();
      test_reset_mid();
      test_wrap();
      test_os1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prbs_qpsk_tx.md
PRBS_QPSK_TX -- requirements
Module: prbs_qpsk_tx

Interface
REQ-001 The block SHALL have parameter NB_OUTPUT, default 8, meaning output sample width in bits.
REQ-002 The block SHALL have parameter NBF_OUTPUT, default 7, meaning output fractional bits, so samples are S(8,7).
REQ-003 The block SHALL have parameter OS_FACTOR, default 4, meaning samples per symbol (oversampling), legal range 1..16.
REQ-004 The block SHALL have parameter SEED_I, default 9'h1AA, meaning the reset value of the I-channel LFSR.
REQ-005 The block SHALL have parameter SEED_Q, default 9'h1FE, meaning the reset value of the Q-channel LFSR.
REQ-006 The block SHALL have port i_clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port i_enable, input, 1 bit: advances the sample-phase counter when high.
REQ-009 The block SHALL have port o_valid, output, 1 bit: the output sample is valid this cycle.
REQ-010 The block SHALL have port o_strobe, output, 1 bit: the current sample is a symbol instant (phase 0).
REQ-011 The block SHALL have ports o_symb_I and o_symb_Q, output, signed NB_OUTPUT bits each: the I and Q samples that feed top_fir i_symb_I and i_symb_Q.
REQ-012 The block SHALL have ports o_bit_I and o_bit_Q, output, 1 bit each: the raw PRBS bits of the current symbol, for a downstream BER checker.

Function
REQ-013 Each channel SHALL run a PRBS9 with polynomial x^9+x^5+1: the output bit is lfsr[8], and next lfsr = {lfsr[7:0], lfsr[8]^lfsr[4]}.
REQ-014 Mapping SHALL be: bit 0 -> +0.5 (8'sh40), bit 1 -> -0.5 (8'shC0); for general NB_OUTPUT/NBF_OUTPUT the magnitude is 2^(NBF_OUTPUT-1).
REQ-015 Phase counter SHALL count 0..OS_FACTOR-1 and wrap; it advances only on cycles where i_enable=1.
REQ-016 On an enabled cycle with phase=0, both LFSRs SHALL shift once and the new symbol SHALL be registered to the outputs with o_strobe=1.
REQ-017 On an enabled cycle with phase!=0, outputs SHALL carry the off-symbol sample (see REQ-027/028) with o_strobe=0.
REQ-018 Latency: all outputs SHALL be registered, and o_valid SHALL equal i_enable delayed by exactly 1 cycle.
REQ-019 When i_enable=0, the counter and LFSRs SHALL freeze, o_valid and o_strobe SHALL go to 0 the next cycle, and data outputs SHALL hold their values.
REQ-020 When OS_FACTOR=1, every enabled cycle SHALL be a symbol cycle (o_strobe=o_valid).
REQ-021 LFSR wrap: the sequence period SHALL be 511 symbols and SHALL repeat seamlessly.
REQ-022 SEED_I=0 or SEED_Q=0, or OS_FACTOR outside 1..16, SHALL cause an elaboration error.

Reset
REQ-023 While i_reset=1: LFSRs SHALL be loaded with SEED_I/SEED_Q, phase SHALL be 0, and o_valid, o_strobe, o_symb_I, o_symb_Q, o_bit_I, o_bit_Q SHALL all be 0.
REQ-024 Reset SHALL take priority over i_enable in the same cycle.
REQ-025 Reset asserted mid-symbol SHALL abandon the symbol; the first enabled cycle after release SHALL emit symbol 0 of the sequence with o_strobe=1.

Configuration
REQ-026 The block SHALL use macro TX_ZERO_STUFF_EN.
REQ-027 With TX_ZERO_STUFF_EN defined, off-symbol samples SHALL be 0 on both I and Q, while o_bit_I/o_bit_Q hold the current symbol bits.
REQ-028 Without TX_ZERO_STUFF_EN, off-symbol samples SHALL repeat the current symbol value (sample-and-hold upsampling).

Structure
REQ-029 Package tx_pkg SHALL hold LFSR_WIDTH=9, the tap positions (8, 4), and the constants SYM_POS and SYM_NEG.
REQ-030 One sub-module, prbs9_lfsr (inputs clock, reset, shift enable, seed parameter; output bit), SHALL be instantiated twice, once for I and once for Q.

Verification
REQ-031 Reset, then i_enable=1 with OS_FACTOR=4 and the default seeds -> o_symb_I at symbols 0,1,2 = 8'hC0, 8'hC0, 8'h40, and o_strobe is high every 4th valid cycle.
REQ-032 Continuous enable for 511*4 cycles -> the I bit sequence repeats exactly at symbol 511.
REQ-033 i_enable toggled 1,0,0,1 in mid-symbol -> phase resumes with no lost or duplicated sample, and o_valid follows i_enable with 1-cycle delay.
REQ-034 i_reset pulsed at phase 2 -> the next output after release has o_strobe=1 and o_symb_I=8'hC0.
REQ-035 With TX_ZERO_STUFF_EN defined -> phases 1..3 give o_symb_I=o_symb_Q=0; without it -> phases 1..3 equal the phase-0 value.
REQ-036 OS_FACTOR=1 -> o_strobe=1 on every valid cycle, and the first three I symbols are C0, C0, 40.
